sobel_window_3x3: RTL and testbench

// Streaming 3x3 neighbourhood generator placed directly after the pixel source and ahead of the Sobel gradient stage.

---
 rtl/sobel_pkg.sv | 24 ++
 rtl/sync_ram_block.sv | 39 +++
 rtl/sobel_window_3x3.sv | 154 +++++++++++++++
 tb/tb_sobel_window_3x3.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the 3x3 Sobel window generator.
// Latency: n/a (types, constants and a pure index helper only).
// Backpressure: n/a.
//
// Pixel type is built from a macro so each module can size it from its own
// WIDTH_P parameter while keeping a single definition of the pixel shape.
`ifndef SOBEL_PKG_SV
`define SOBEL_PKG_SV

`define SOBEL_PIX_T(W) logic [(W)-1:0]

package sobel_pkg;

    localparam int unsigned WIN_TAPS = 9;
    localparam int unsigned WIN_DIM  = 3;

    // Flat tap index of window pixel (r,c); r0 is the oldest row, c0 the leftmost column.
    function automatic int unsigned idx(input int unsigned r, input int unsigned c);
        return r * WIN_DIM + c;
    endfunction

endpackage

`endif

// File: rtl/sync_ram_block.sv
// Single-clock line memory with registered read; read-before-write on address collision.
// Latency: read data appears one cycle after rd_en_i.
// Backpressure: none; rd_data_o holds its value while rd_en_i is low.
//
// Ports:
//   clk_i      clock
//   rd_en_i    read enable; rd_addr_i sampled on this edge
//   rd_addr_i  read address
//   wr_en_i    write enable
//   wr_addr_i  write address
//   wr_data_i  write data
//   rd_data_o  registered read data
module sync_ram_block #(
    parameter int unsigned DEPTH_P = 640,
    parameter int unsigned WIDTH_P = 8,
    localparam int unsigned AW     = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1
) (
    input  logic               clk_i,
    input  logic               rd_en_i,
    input  logic [AW-1:0]      rd_addr_i,
    input  logic               wr_en_i,
    input  logic [AW-1:0]      wr_addr_i,
    input  logic [WIDTH_P-1:0] wr_data_i,
    output logic [WIDTH_P-1:0] rd_data_o
);

    logic [WIDTH_P-1:0] mem [DEPTH_P];

    // Contents are deliberately not reset; consumers gate on their own counters.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem[rd_addr_i];
        end
    end

endmodule

// File: rtl/sobel_window_3x3.sv
// Streams raster pixels into two line memories and emits every complete 3x3 neighbourhood.
// Latency: pixel accepted at edge k drives its window on valid_o after edge k+1.
// Backpressure: ready_o = !s1_valid || s1_adv (combinational from ready_i); full rate when ready_i high.
//
// Ports:
//   clk_i     clock
//   rstn_i    asynchronous active-low reset
//   valid_i   input pixel valid
//   ready_o   input ready; beat accepted on valid_i && ready_o
//   sof_i     start of frame, qualified by an accepted beat
//   data_i    input pixel, raster order
//   valid_o   window valid
//   ready_i   downstream ready
//   window_o  pixel(r,c) at [(r*3+c)*WIDTH_P +: WIDTH_P]
module sobel_window_3x3
    import sobel_pkg::*;
#(
    parameter int unsigned WIDTH_P  = 8,
    parameter int unsigned LINE_W_P = 640
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic                        sof_i,
    input  logic [WIDTH_P-1:0]          data_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [WIN_TAPS*WIDTH_P-1:0] window_o
);

    localparam int unsigned COL_W = $clog2(LINE_W_P);

    typedef `SOBEL_PIX_T(WIDTH_P) pix_t;
    typedef logic [COL_W-1:0] col_t;
    typedef logic [1:0]       row_t;

    localparam col_t COL_LAST = col_t'(LINE_W_P - 1);
    localparam row_t ROW_FULL = 2'd2;

    col_t col_q;
    row_t row_q;
    col_t col_cur;
    row_t row_cur;

    pix_t pix_s1;
    col_t col_s1;
    row_t row_s1;
    logic s1_valid;
    logic s1_adv;
    logic accept;
    logic emit;

    pix_t line0_rd;
    pix_t line1_rd;

    logic                        valid_q;
    logic [WIN_TAPS*WIDTH_P-1:0] window_q;
    logic [WIN_TAPS*WIDTH_P-1:0] window_nx;

    // sof forces this beat to the frame origin; counters continue from it.
    assign col_cur = sof_i ? '0 : col_q;
    assign row_cur = sof_i ? '0 : row_q;

    assign s1_adv  = s1_valid && (!valid_q || ready_i);
    assign ready_o = !s1_valid || s1_adv;
    assign accept  = valid_i && ready_o;

    // The first two columns of a row carry stale data from the previous row's tail.
    assign emit = (row_s1 >= ROW_FULL) && (col_s1 >= col_t'(2));

    assign valid_o  = valid_q;
    assign window_o = window_q;

    // line0 holds the previous row; read-before-write returns it while the new row overwrites it.
    sync_ram_block #(
        .DEPTH_P (LINE_W_P),
        .WIDTH_P (WIDTH_P)
    ) u_line0 (
        .clk_i     (clk_i),
        .rd_en_i   (accept),
        .rd_addr_i (col_cur),
        .wr_en_i   (accept),
        .wr_addr_i (col_cur),
        .wr_data_i (data_i),
        .rd_data_o (line0_rd)
    );

    // line1 holds the row before that; it is fed from line0's output as S1 advances,
    // always one column behind the next read, so the two never collide.
    sync_ram_block #(
        .DEPTH_P (LINE_W_P),
        .WIDTH_P (WIDTH_P)
    ) u_line1 (
        .clk_i     (clk_i),
        .rd_en_i   (accept),
        .rd_addr_i (col_cur),
        .wr_en_i   (s1_adv),
        .wr_addr_i (col_s1),
        .wr_data_i (line0_rd),
        .rd_data_o (line1_rd)
    );

    always_comb begin
        window_nx = window_q;
        for (int unsigned r = 0; r < WIN_DIM; r++) begin
            for (int unsigned c = 0; c < WIN_DIM - 1; c++) begin
                window_nx[idx(r, c) * WIDTH_P +: WIDTH_P] = window_q[idx(r, c + 1) * WIDTH_P +: WIDTH_P];
            end
        end
        window_nx[idx(0, 2) * WIDTH_P +: WIDTH_P] = line1_rd;
        window_nx[idx(1, 2) * WIDTH_P +: WIDTH_P] = line0_rd;
        window_nx[idx(2, 2) * WIDTH_P +: WIDTH_P] = pix_s1;
    end

    // S0: counters and S1 capture.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            col_q    <= '0;
            row_q    <= '0;
            pix_s1   <= '0;
            col_s1   <= '0;
            row_s1   <= '0;
            s1_valid <= 1'b0;
        end else begin
            if (accept) begin
                col_q  <= (col_cur == COL_LAST) ? '0 : col_cur + col_t'(1);
                row_q  <= ((col_cur == COL_LAST) && (row_cur != ROW_FULL)) ? row_cur + row_t'(1) : row_cur;
                pix_s1 <= data_i;
                col_s1 <= col_cur;
                row_s1 <= row_cur;
            end
            if (accept) begin
                s1_valid <= 1'b1;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // S1: window shift and output handshake.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_q  <= 1'b0;
            window_q <= '0;
        end else if (s1_adv) begin
            valid_q  <= emit;
            window_q <= window_nx;
        end else if (valid_q && ready_i) begin
            valid_q  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sobel_window_3x3.sv
module tb_sobel_window_3x3;

    localparam int LW = 4;
    localparam int PW = 8;
    localparam int WW = 9 * PW;
    localparam int ACC_LIMIT = 200;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          valid_i;
    logic          ready_o;
    logic          sof_i;
    logic [PW-1:0] data_i;
    logic          valid_o;
    logic          ready_i;
    logic [WW-1:0] window_o;

    int checks = 0;
    int errors = 0;
    int rmode  = 0;
    int cyc    = 0;
    int stalls = 0;

    logic [WW-1:0] got[$];
    logic [WW-1:0] exp_q[$];

    logic          prev_stall = 1'b0;
    logic          prev_fill  = 1'b0;
    logic [WW-1:0] prev_win   = '0;

    sobel_window_3x3 #(.WIDTH_P(PW), .LINE_W_P(LW)) dut (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .sof_i    (sof_i),
        .data_i   (data_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .window_o (window_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: window for raster pixel i of a frame whose pixel values are base + raster index.
    function automatic logic [WW-1:0] mk_win(input int base, input int i);
        logic [WW-1:0] w;
        int rr;
        int cc;
        rr = i / LW;
        cc = i % LW;
        w  = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w[(r * 3 + c) * PW +: PW] = PW'(base + (rr - 2 + r) * LW + (cc - 2 + c));
            end
        end
        return w;
    endfunction

    // Every pixel with at least two rows above and two columns to its left yields a window.
    task automatic model_frame(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            if ((i / LW) >= 2 && (i % LW) >= 2) exp_q.push_back(mk_win(base, i));
        end
    endtask

    // Downstream ready generator: 0 = held low, 1 = held high, 2 = pattern 1,0,0,1.
    initial begin
        ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            cyc++;
            ready_i = (rmode == 1) || (rmode == 2 && ((cyc % 4) == 0 || (cyc % 4) == 3));
        end
    end

    // Output monitor: collects transfers and checks hold/backpressure rules mid-cycle.
    always @(negedge clk_i) begin
        if (!rstn_i) begin
            prev_stall <= 1'b0;
            prev_fill  <= 1'b0;
        end else begin
            if (valid_o && ready_i) got.push_back(window_o);
            if (prev_stall) begin
                chk("hold_valid", WW'(valid_o), WW'(1));
                chk("hold_window", window_o, prev_win);
            end
            if (prev_fill && valid_o && !ready_i) chk("stall_ready_low", WW'(ready_o), WW'(0));
            if (ready_i) chk("ready_follow", WW'(ready_o), WW'(1));
            prev_stall <= valid_o && !ready_i;
            prev_fill  <= valid_o && !ready_i && valid_i;
            prev_win   <= window_o;
        end
    end

    task automatic send(input int v, input logic s, input bit gaps);
        logic acc;
        int   n;
        int   g;
        g = 0;
        while (gaps && $urandom_range(0, 1) == 1 && g < 3) begin
            valid_i = 1'b0;
            data_i  = PW'($urandom);
            sof_i   = 1'($urandom);
            g++;
            @(posedge clk_i);
            #1;
        end
        valid_i = 1'b1;
        data_i  = PW'(v);
        sof_i   = s;
        n       = 0;
        acc     = 1'b0;
        while (!acc && n < ACC_LIMIT) begin
            @(negedge clk_i);
            acc = ready_o;
            @(posedge clk_i);
            #1;
            if (!acc) n++;
        end
        checks++;
        assert (acc) else begin
            errors++;
            $error("FAIL accept_timeout: observed %0d cycles without accept, required < %0d", n, ACC_LIMIT);
        end
        if (n > 0) stalls++;
        valid_i = 1'b0;
        sof_i   = 1'b0;
        data_i  = PW'($urandom);
    endtask

    task automatic drain();
        repeat (20) @(posedge clk_i);
        #1;
    endtask

    task automatic cmp_windows(input string tag);
        chk({tag, "_count"}, WW'(got.size()), WW'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk(tag, got[i], exp_q[i]);
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        rstn_i  = 1'b0;
        valid_i = 1'b0;
        sof_i   = 1'b0;
        data_i  = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid", WW'(valid_o), WW'(0));
        chk("rst_window", window_o, WW'(0));
        chk("rst_ready", WW'(ready_o), WW'(1));
        rstn_i = 1'b1;
        rmode  = 1;
        @(posedge clk_i);
        #1;

        // Scenario 1: one frame at full rate, with latency check around pixel 10.
        for (int i = 0; i < 16; i++) begin
            send(i, i == 0, 1'b0);
            if (i == 9 || i == 10) chk("lat_pre", WW'(valid_o), WW'(0));
            if (i == 11) chk("lat_rise", WW'(valid_o), WW'(1));
        end
        drain();
        model_frame(0, 16);
        if (got.size() == 4) begin
            chk("s1_first", got[0], 72'h0A0908_060504_020100);
            chk("s1_last", got[3], 72'h0F0E0D_0B0A09_070605);
        end
        cmp_windows("s1_win");

        // Scenario 2: downstream ready 1,0,0,1.
        rmode = 2;
        for (int i = 0; i < 16; i++) send(i, i == 0, 1'b0);
        drain();
        model_frame(0, 16);
        cmp_windows("s2_win");

        // Scenario 3: random input gaps with garbage on idle beats.
        rmode = 1;
        for (int i = 0; i < 16; i++) send(i, i == 0, 1'b1);
        drain();
        model_frame(0, 16);
        cmp_windows("s3_win");

        // Scenario 4: truncated frame then a new frame.
        for (int i = 0; i < 10; i++) send(i, i == 0, 1'b0);
        for (int i = 0; i < 16; i++) send(100 + i, i == 0, 1'b0);
        drain();
        model_frame(0, 10);
        model_frame(100, 16);
        if (got.size() > 0) chk("s4_first", got[0], 72'h6E6D6C_6A6968_666564);
        cmp_windows("s4_win");

        // Scenario 5: reset while a window is pending and downstream is stalled.
        rmode = 0;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 12; i++) send(i, i == 0, 1'b0);
        chk("s5_pending", WW'(valid_o), WW'(1));
        chk("s5_none_taken", WW'(got.size()), WW'(0));
        rstn_i = 1'b0;
        #1;
        chk("s5_rst_valid", WW'(valid_o), WW'(0));
        chk("s5_rst_window", window_o, WW'(0));
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        rmode  = 1;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 16; i++) send(i, 1'b0, 1'b0);
        drain();
        model_frame(0, 16);
        cmp_windows("s5_win");

        // Scenario 6: two frames back to back, full rate required.
        stalls = 0;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 16; i++) send(i, i == 0, 1'b0);
        end
        drain();
        chk("s6_stalls", WW'(stalls), WW'(0));
        model_frame(0, 16);
        model_frame(0, 16);
        cmp_windows("s6_win");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
